// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy -- single-channel memory-to-memory word copy engine.
//
// Software programs SRC, DST and LEN through the responder port and writes
// CTRL.START. The engine then copies LEN 32-bit words, one read and one write
// per word, through the initiator port.
//
// Register map (by cfg_in.mem_addr[4:0], offsets >= 0x10 answer with error):
//   0x00 SRC   word-aligned source address
//   0x04 DST   word-aligned destination address
//   0x08 LEN   word count, LEN_W bits
//   0x0C CTRL  bit0 START (w1 pulse), bit1 BUSY (ro), bit2 DONE (w1c),
//              bit3 ERR (w1c), bit4 IE (rw, only with DMA_COPY_IRQ_EN)
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   cfg_in       register-access request from the soc address decoder
//   cfg_out      register-access response, registered, one cycle later
//   dma_mem_in   initiator request to the memory bus
//   dma_mem_out  memory bus response to the initiator
//   dma_irpt     level interrupt
//
// Parameter:
//   LEN_W        width of the word-count register, 1..31
//
// Build option:
//   DMA_COPY_IRQ_EN  when defined, CTRL.IE exists and dma_irpt is driven as a
//                    registered IE & (DONE | ERR); otherwise dma_irpt is 0.
// -----------------------------------------------------------------------------
package dma_copy_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

endpackage

module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  cfg_in,
    output mem_out_type cfg_out,
    output mem_in_type  dma_mem_in,
    input  mem_out_type dma_mem_out,
    output logic        dma_irpt
);

    typedef enum logic [2:0] { IDLE, RD, RD_GAP, WR, WR_GAP } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q, err_q;
    logic [31:0]      work_src_q, work_dst_q, buf_q;
    logic [LEN_W-1:0] cnt_q;
    mem_out_type      cfg_out_q;

    logic             cfg_bad, cfg_write, busy;
    logic [1:0]       cfg_sel;
    logic             src_we, dst_we, len_we, ctrl_we, start;
    logic             done_w1c, err_w1c;
    logic             load, buf_we, advance, done_set, err_set;
    logic             done_d, err_d, ie_rd;
    logic [31:0]      len_wide, rdata_d;
    logic             unused_bits;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        return {strb[3] ? new_val[31:24] : old_val[31:24],
                strb[2] ? new_val[23:16] : old_val[23:16],
                strb[1] ? new_val[15:8]  : old_val[15:8],
                strb[0] ? new_val[7:0]   : old_val[7:0]};
    endfunction

    // Register decode. SRC/DST/LEN and START are locked while a copy is in
    // flight so the working copies cannot be disturbed; the access itself
    // still completes without error.
    assign cfg_bad   = |cfg_in.mem_addr[31:4];
    assign cfg_sel   = cfg_in.mem_addr[3:2];
    assign cfg_write = cfg_in.mem_valid & ~cfg_bad & (|cfg_in.mem_wstrb);
    assign busy      = (state_q != IDLE);
    assign src_we    = cfg_write & ~busy & (cfg_sel == 2'd0);
    assign dst_we    = cfg_write & ~busy & (cfg_sel == 2'd1);
    assign len_we    = cfg_write & ~busy & (cfg_sel == 2'd2);
    assign ctrl_we   = cfg_write & (cfg_sel == 2'd3) & cfg_in.mem_wstrb[0];
    assign start     = ctrl_we & ~busy & cfg_in.mem_wdata[0];
    assign done_w1c  = ctrl_we & cfg_in.mem_wdata[2];
    assign err_w1c   = ctrl_we & cfg_in.mem_wdata[3];
    assign len_wide  = merge_lanes({{(32-LEN_W){1'b0}}, len_q},
                                   cfg_in.mem_wdata, cfg_in.mem_wstrb);

    // Hardware sets of DONE/ERR take priority over a software clear in the
    // same cycle; a fresh START wipes both.
    assign done_d = done_set | (done_q & ~(load | done_w1c));
    assign err_d  = err_set  | (err_q  & ~(load | err_w1c));

    // Read data reflects register state before any write in the same cycle.
    always_comb begin
        rdata_d = '0;
        case (cfg_sel)
            2'd0: rdata_d = src_q;
            2'd1: rdata_d = dst_q;
            2'd2: rdata_d = {{(32-LEN_W){1'b0}}, len_q};
            2'd3: rdata_d = {27'd0, ie_rd, err_q, done_q, busy, 1'b0};
            default: rdata_d = '0;
        endcase
    end

    // Programming registers and the registered responder port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cfg_out_q <= init_mem_out;
        end else begin
            if (src_we)
                src_q <= merge_lanes(src_q, cfg_in.mem_wdata, cfg_in.mem_wstrb) & 32'hFFFF_FFFC;
            if (dst_we)
                dst_q <= merge_lanes(dst_q, cfg_in.mem_wdata, cfg_in.mem_wstrb) & 32'hFFFF_FFFC;
            if (len_we)
                len_q <= len_wide[LEN_W-1:0];
            done_q              <= done_d;
            err_q               <= err_d;
            cfg_out_q.mem_ready <= cfg_in.mem_valid;
            cfg_out_q.mem_error <= cfg_in.mem_valid & cfg_bad;
            cfg_out_q.mem_rdata <= (cfg_in.mem_valid & ~cfg_bad) ? rdata_d : 32'd0;
        end
    end

    assign cfg_out = cfg_out_q;

    // Copy engine state register and working copies. The request outputs
    // below decode straight from this state, so an asynchronous reset drops
    // mem_valid immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            work_src_q <= '0;
            work_dst_q <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                work_src_q <= src_q;
                work_dst_q <= dst_q;
                cnt_q      <= len_q;
            end
            if (buf_we)
                buf_q <= dma_mem_out.mem_rdata;
            if (advance) begin
                work_src_q <= work_src_q + 32'd4;
                work_dst_q <= work_dst_q + 32'd4;
                cnt_q      <= cnt_q - LEN_W'(1);
            end
        end
    end

    // Next-state and initiator request. Each word is read, a one-cycle gap,
    // written, another gap; bus responses outside RD/WR are ignored.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        buf_we     = 1'b0;
        advance    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        dma_mem_in = init_mem_in;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_q != '0) begin
                        load    = 1'b1;
                        state_d = RD;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            RD: begin
                dma_mem_in.mem_valid = 1'b1;
                dma_mem_in.mem_addr  = work_src_q;
                if (dma_mem_out.mem_ready) begin
                    if (dma_mem_out.mem_error) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        buf_we  = 1'b1;
                        state_d = RD_GAP;
                    end
                end
            end
            RD_GAP: state_d = WR;
            WR: begin
                dma_mem_in.mem_valid = 1'b1;
                dma_mem_in.mem_addr  = work_dst_q;
                dma_mem_in.mem_wdata = buf_q;
                dma_mem_in.mem_wstrb = 4'hF;
                if (dma_mem_out.mem_ready) begin
                    if (dma_mem_out.mem_error) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = WR_GAP;
                    end
                end
            end
            WR_GAP: begin
                if (cnt_q == '0) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DMA_COPY_IRQ_EN
    logic ie_q, ie_d, irpt_q;

    assign ie_d = ctrl_we ? cfg_in.mem_wdata[4] : ie_q;

    // Interrupt is registered from the next-cycle flag values so it rises
    // together with DONE/ERR and falls together with their clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ie_q   <= 1'b0;
            irpt_q <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            irpt_q <= ie_d & (done_d | err_d);
        end
    end

    assign ie_rd    = ie_q;
    assign dma_irpt = irpt_q;
`else
    assign ie_rd    = 1'b0;
    assign dma_irpt = 1'b0;
`endif

    assign unused_bits = ^{cfg_in.mem_instr, cfg_in.mem_addr[1:0], len_wide[31:LEN_W]};

endmodule
